// File: rtl/reg_file_pkg.sv
// Shared sizing for the register file: defaults, address-width helper, busy-vector type.
package reg_file_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;

   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   typedef logic [DEF_DEPTH-1:0] busy_vec_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bus of the scoreboarded register file.
interface reg_file_sb_if
   import reg_file_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) ();
   localparam int AW = addr_w(DEPTH);

   logic [AW-1:0]    rd_addr_a;
   logic [WIDTH-1:0] rd_data_a;
   logic             busy_a;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_b;
   logic             busy_b;
   logic             write;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             claim;
   logic [AW-1:0]    claim_addr;
   logic [AW:0]      busy_count;

   modport master (
      output rd_addr_a, rd_addr_b, write, wr_addr, wr_data, claim, claim_addr,
      input  rd_data_a, busy_a, rd_data_b, busy_b, busy_count
   );
   modport slave (
      input  rd_addr_a, rd_addr_b, write, wr_addr, wr_data, claim, claim_addr,
      output rd_data_a, busy_a, rd_data_b, busy_b, busy_count
   );
endinterface

// File: rtl/reg_file_entry.sv
// One storage word plus its busy bit; write and claim are active-low, claim wins on busy.
module reg_file_entry #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic             claim,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] data,
   output logic             busy
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data <= '0;
         busy <= 1'b0;
      end else begin
         if (!write) begin
            data <= wr_data;
            busy <= 1'b0;
         end
         // A same-edge claim models a newer producer, so it overrides the clear.
         if (!claim)
            busy <= 1'b1;
      end
   end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-entry busy scoreboard, two async read ports and a registered busy count.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data/busy to the read ports.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   reg_file_sb_if.slave bus
);
   localparam int AW = addr_w(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [DEPTH-1:0]            busy;
   logic [DEPTH-1:0]            busy_nxt;
   logic [DEPTH-1:0]            we_n;
   logic [DEPTH-1:0]            cl_n;
   logic [AW:0]                 cnt_nxt;
   logic [AW:0]                 cnt_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         we_n[i]     = bus.write | (bus.wr_addr != AW'(i));
         cl_n[i]     = bus.claim | (bus.claim_addr != AW'(i));
         busy_nxt[i] = !cl_n[i] ? 1'b1 : (!we_n[i] ? 1'b0 : busy[i]);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      reg_file_entry #(.WIDTH(WIDTH)) u_ent (
         .clk     (clk),
         .reset   (reset),
         .write   (we_n[g]),
         .claim   (cl_n[g]),
         .wr_data (bus.wr_data),
         .data    (mem[g]),
         .busy    (busy[g])
      );
   end

   // Count is the popcount of the post-edge busy vector, so it can never wrap.
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_nxt;
   end

   assign bus.busy_count = cnt_q;

`ifdef REG_FILE_BYPASS_EN
   always_comb begin
      bus.rd_data_a = mem[bus.rd_addr_a];
      bus.busy_a    = busy[bus.rd_addr_a];
      bus.rd_data_b = mem[bus.rd_addr_b];
      bus.busy_b    = busy[bus.rd_addr_b];
      // Gated by reset so the ports read zero while reset is held.
      if (reset && !bus.write && bus.wr_addr == bus.rd_addr_a) begin
         bus.rd_data_a = bus.wr_data;
         bus.busy_a    = !bus.claim && bus.claim_addr == bus.rd_addr_a;
      end
      if (reset && !bus.write && bus.wr_addr == bus.rd_addr_b) begin
         bus.rd_data_b = bus.wr_data;
         bus.busy_b    = !bus.claim && bus.claim_addr == bus.rd_addr_b;
      end
   end
`else
   assign bus.rd_data_a = mem[bus.rd_addr_a];
   assign bus.busy_a    = busy[bus.rd_addr_a];
   assign bus.rd_data_b = mem[bus.rd_addr_b];
   assign bus.busy_b    = busy[bus.rd_addr_b];
`endif
endmodule
